// File: rtl/n_demux_reg.sv
// n_demux_reg: 16-way register-file write demux with a one-hot write strobe.
// Latency: word captured at E0, written at E1, visible and strobed in the cycle after E1.
// Backpressure: in_ready drops for the WRITE cycle; one word accepted per 2 cycles.
// Optional build macro N_DEMUX_REG_PROTECT_EN adds the protect input and the wr_err output.
module n_demux_reg #(
  parameter int n = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [n-1:0]    din,
  input  logic [3:0]      sel,
  output logic [16*n-1:0] q_flat,
  output logic [15:0]     wr_strobe,
  output logic            busy
`ifdef N_DEMUX_REG_PROTECT_EN
  ,
  input  logic [15:0]     protect,
  output logic [0:0]      wr_err
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] din_s_q;
  logic [3:0]   sel_s_q;
  logic [n-1:0] regs_q [16];
  logic [15:0]  strobe_q;
  logic         capture;
  logic         commit;
  logic         write_ok;

`ifdef N_DEMUX_REG_PROTECT_EN
  logic         prot_s_q;
  logic         err_q;
`endif

  // Next state and handshake outputs; ready/busy depend only on state and clr.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    capture  = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~clr;
        capture  = in_valid;
        if (in_valid) state_d = WRITE;
      end
      WRITE: begin
        busy    = ~clr;
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef N_DEMUX_REG_PROTECT_EN
  assign write_ok = commit & ~prot_s_q;
`else
  assign write_ok = commit;
`endif

  // State register and staging of the accepted word; WRITE never resamples inputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      din_s_q <= '0;
      sel_s_q <= '0;
`ifdef N_DEMUX_REG_PROTECT_EN
      prot_s_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (capture) begin
        din_s_q <= din;
        sel_s_q <= sel;
`ifdef N_DEMUX_REG_PROTECT_EN
        prot_s_q <= protect[sel];
`endif
      end
    end
  end

  // Destination registers: only the staged index changes, and only when the write is allowed.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < 16; k++) regs_q[k] <= '0;
    end else if (write_ok) begin
      regs_q[sel_s_q] <= din_s_q;
    end
  end

  // Strobe is rebuilt every edge, so it can never stay high past one cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= write_ok ? (16'h0001 << sel_s_q) : 16'h0000;
    end
  end

`ifdef N_DEMUX_REG_PROTECT_EN
  // Error pulse occupies the slot the strobe would have used for a blocked write.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= commit & prot_s_q;
    end
  end

  assign wr_err = err_q;
`endif

  assign wr_strobe = strobe_q;

  for (genvar g = 0; g < 16; g++) begin : g_flat
    assign q_flat[g*n +: n] = regs_q[g];
  end

endmodule

// File: tb/tb_n_demux_reg.sv
// Directed bench for n_demux_reg: reset, single write, back-to-back, stall,
// full overwrite sweep, optional protect path and mid-run reset.
module tb_n_demux_reg;

  localparam int N = 32;

  logic            clk;
  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    din;
  logic [3:0]      sel;
  logic [16*N-1:0] q_flat;
  logic [15:0]     wr_strobe;
  logic            busy;
`ifdef N_DEMUX_REG_PROTECT_EN
  logic [15:0]     protect;
  logic [0:0]      wr_err;
`endif

  int checks = 0;
  int passed = 0;

  n_demux_reg #(.n(N)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .sel       (sel),
    .q_flat    (q_flat),
    .wr_strobe (wr_strobe),
    .busy      (busy)
`ifdef N_DEMUX_REG_PROTECT_EN
    ,
    .protect   (protect),
    .wr_err    (wr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] reg_at(input int k);
    return q_flat[k*N +: N];
  endfunction

  // Present one word in IDLE and return once the write edge has passed.
  task automatic write_word(input logic [3:0] s, input logic [N-1:0] d);
    @(negedge clk);
    in_valid = 1'b1; sel = s; din = d;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1; in_valid = 1'b0; din = '0; sel = '0;
`ifdef N_DEMUX_REG_PROTECT_EN
    protect = '0;
`endif
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready_low got=%b exp=0", in_ready); else passed++;
    @(negedge clk); @(negedge clk);
    checks++; if (q_flat !== '0) $display("FAIL reset_q_flat got=%h exp=0", q_flat); else passed++;
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL reset_strobe got=%h exp=0000", wr_strobe); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    clr = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready_after got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_single_write();
    logic [16*N-1:0] exp_flat;
    exp_flat = '0;
    exp_flat[5*N +: N] = 32'hDEADBEEF;
    @(negedge clk);
    in_valid = 1'b1; sel = 4'd5; din = 32'hDEADBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL single_ready got=%b exp=0", in_ready); else passed++;
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL single_strobe_early got=%h exp=0000", wr_strobe); else passed++;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h0020) $display("FAIL single_strobe got=%h exp=0020", wr_strobe); else passed++;
    checks++; if (q_flat !== exp_flat) $display("FAIL single_q_flat got=%h exp=%h", q_flat, exp_flat); else passed++;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL single_strobe_clear got=%h exp=0000", wr_strobe); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_clear got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; sel = 4'd0; din = 32'd1;
    @(negedge clk);
    sel = 4'd15; din = 32'd2;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_busy1 got=%b exp=1", busy); else passed++;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h0001) $display("FAIL b2b_strobe0 got=%h exp=0001", wr_strobe); else passed++;
    checks++; if (reg_at(0) !== 32'd1) $display("FAIL b2b_reg0 got=%h exp=1", reg_at(0)); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", in_ready); else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL b2b_gap got=%h exp=0000", wr_strobe); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_busy2 got=%b exp=1", busy); else passed++;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h8000) $display("FAIL b2b_strobe15 got=%h exp=8000", wr_strobe); else passed++;
    checks++; if (reg_at(15) !== 32'd2) $display("FAIL b2b_reg15 got=%h exp=2", reg_at(15)); else passed++;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL b2b_strobe_clear got=%h exp=0000", wr_strobe); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_no_dup got=%b exp=0", busy); else passed++;
    checks++; if (reg_at(0) !== 32'd1) $display("FAIL b2b_reg0_hold got=%h exp=1", reg_at(0)); else passed++;
  endtask

  task automatic test_stall();
    @(negedge clk);
    in_valid = 1'b1; sel = 4'd7; din = 32'h0000_0777;
    @(negedge clk);
    in_valid = 1'b0; din = 32'h0000_0BAD;
    #2 in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (wr_strobe !== 16'h0080) $display("FAIL stall_strobe got=%h exp=0080", wr_strobe); else passed++;
    checks++; if (reg_at(7) !== 32'h0000_0777) $display("FAIL stall_reg7 got=%h exp=00000777", reg_at(7)); else passed++;
    @(negedge clk);
    @(negedge clk);
    checks++; if (reg_at(7) !== 32'h0000_0777) $display("FAIL stall_reg7_hold got=%h exp=00000777", reg_at(7)); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL stall_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_overwrite_all();
    for (int k = 0; k < 16; k++) write_word(4'(k), 32'(k + 100));
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (reg_at(k) !== 32'(k + 100)) $display("FAIL sweep_reg%0d got=%0d exp=%0d", k, reg_at(k), k + 100);
      else passed++;
    end
    @(negedge clk);
    in_valid = 1'b1; sel = 4'd3; din = 32'd103;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h0008) $display("FAIL rewrite_strobe got=%h exp=0008", wr_strobe); else passed++;
    checks++; if (reg_at(3) !== 32'd103) $display("FAIL rewrite_reg3 got=%0d exp=103", reg_at(3)); else passed++;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL rewrite_clear got=%h exp=0000", wr_strobe); else passed++;
  endtask

`ifdef N_DEMUX_REG_PROTECT_EN
  task automatic test_protect();
    protect = 16'h0004;
    @(negedge clk);
    in_valid = 1'b1; sel = 4'd2; din = 32'd55;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL prot_busy got=%b exp=1", busy); else passed++;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL prot_strobe got=%h exp=0000", wr_strobe); else passed++;
    checks++; if (wr_err !== 1'b1) $display("FAIL prot_err got=%b exp=1", wr_err); else passed++;
    checks++; if (reg_at(2) !== 32'd102) $display("FAIL prot_reg2 got=%0d exp=102", reg_at(2)); else passed++;
    @(negedge clk);
    checks++; if (wr_err !== 1'b0) $display("FAIL prot_err_clear got=%b exp=0", wr_err); else passed++;
    in_valid = 1'b1; sel = 4'd1; din = 32'd77;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h0002) $display("FAIL prot_ok_strobe got=%h exp=0002", wr_strobe); else passed++;
    checks++; if (reg_at(1) !== 32'd77) $display("FAIL prot_ok_reg1 got=%0d exp=77", reg_at(1)); else passed++;
    checks++; if (wr_err !== 1'b0) $display("FAIL prot_ok_err got=%b exp=0", wr_err); else passed++;
    @(negedge clk);
    protect = 16'h0000;
  endtask
`endif

  task automatic test_mid_reset();
    @(negedge clk);
    checks++; if (q_flat === '0) $display("FAIL midrst_precond got=%h exp=nonzero", q_flat); else passed++;
    in_valid = 1'b1; sel = 4'd9; din = 32'hAAAA_5555;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL midrst_pending got=%b exp=1", busy); else passed++;
    clr = 1'b1;
    #1;
    checks++; if (q_flat !== '0) $display("FAIL midrst_q_flat got=%h exp=0", q_flat); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", in_ready); else passed++;
    @(negedge clk);
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL midrst_strobe got=%h exp=0000", wr_strobe); else passed++;
    clr = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL midrst_ready_after got=%b exp=1", in_ready); else passed++;
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL midrst_no_strobe got=%h exp=0000", wr_strobe); else passed++;
    @(negedge clk); @(negedge clk);
    checks++; if (q_flat !== '0) $display("FAIL midrst_dropped got=%h exp=0", q_flat); else passed++;
    checks++; if (wr_strobe !== 16'h0000) $display("FAIL midrst_quiet got=%h exp=0000", wr_strobe); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_stall();
    test_overwrite_all();
`ifdef N_DEMUX_REG_PROTECT_EN
    test_protect();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/n_demux_reg.md
Name: n_demux_reg

Overview:
- Write-side counterpart of the 16:1 n-bit source-select mux on the datapath bus.
- Accepts one n-bit bus word plus a 4-bit destination select through a valid/ready handshake.
- Stores the word into one of 16 destination registers.
- Emits a one-cycle one-hot write strobe for the destination, so downstream logic sees exactly which register changed.

Parameters:
- n, 32, data width of the bus word and of each destination register.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  asynchronous active-high reset.
- in_valid  input  1  source presents din/sel this cycle.
- in_ready  output  1  block can accept a word this cycle.
- din  input  n  bus word to write.
- sel  input  4  destination index 0..15.
- q_flat  output  16*n  destination registers concatenated; register k occupies bits [k*n+n-1 : k*n].
- wr_strobe  output  16  one-hot pulse, bit k high for the cycle in which register k holds a newly written value.
- busy  output  1  high while a captured word is pending write.

Behaviour:
- Reset (clr high, asynchronous, any time):
  - All 16 registers clear to 0; wr_strobe = 0; state = IDLE; staging registers = 0.
  - in_ready is forced 0 while clr is high; busy = 0.
  - A pending write is dropped, with no strobe and no register change.
- State machine, two states, registered:
  - IDLE: in_ready = 1, busy = 0. At a rising edge with in_valid = 1, din -> din_s and sel -> sel_s (capture edge E0); next state WRITE. If in_valid = 0, stay IDLE.
  - WRITE: in_ready = 0, busy = 1; in_valid is ignored and din/sel are not sampled. At the next edge (E1): register[sel_s] <= din_s, wr_strobe <= onehot(sel_s), next state IDLE.
- Latency and throughput:
  - New value is visible on q_flat and the strobe bit is high in the cycle following E1, i.e. two edges after capture.
  - wr_strobe returns to 0 at E2 unconditionally; it is never high for more than one cycle per write.
  - Maximum throughput is one word per 2 cycles. A new word can be accepted at E2, the same edge at which the strobe clears.
- Only the selected register changes at E1; the other 15 registers hold.
- Writing the same value as already stored still produces the strobe.
- sel is 4 bits, so all 16 values are legal; there is no out-of-range case.
- Holding in_valid high across the WRITE cycle does not cause a duplicate capture. The word presented at E2 (if any) is a new transaction.
- in_ready and busy are combinational decodes of the state register, gated by clr; they have no combinational path from in_valid.

Optional Feature:
- Macro: N_DEMUX_REG_PROTECT_EN.
- Defined:
  - Adds input protect [15:0] and output wr_err [0:0].
  - protect[sel] is sampled at E0 together with din/sel.
  - If the sampled bit is 1: the transaction is consumed normally (same handshake, WRITE state entered), but at E1 no register updates, wr_strobe stays 0, and wr_err pulses 1 for one cycle in the slot where the strobe would have been.
  - wr_err resets to 0.
- Undefined: protect and wr_err ports do not exist; every accepted write proceeds.

Test Plan:
- Reset check: assert clr mid-simulation with registers non-zero and a pending WRITE -> q_flat = 0, wr_strobe = 0, busy = 0, in_ready = 0 during clr, in_ready = 1 the cycle after clr falls; the dropped write never appears.
- Single write: din = 32'hDEADBEEF, sel = 4'd5, in_valid for one cycle at E0 -> busy = 1 the next cycle; after E1, register 5 = DEADBEEF and wr_strobe = 16'h0020 for exactly one cycle; all other registers = 0.
- Back-to-back: in_valid held high with (sel = 0, din = 1) then (sel = 15, din = 2) -> accepted at E0 and E2 only; register 0 = 1, register 15 = 2; strobes 16'h0001 and 16'h8000 in separate cycles; no duplicate capture.
- Overwrite plus all indices: write k+100 to each sel = k for k = 0..15, then rewrite sel = 3 with the same value -> every register holds k+100; the rewrite still pulses wr_strobe = 16'h0008.
- Stall: in_valid toggled during WRITE with sel = 7 -> ignored; only the IDLE-cycle word is written.
- Protect (with N_DEMUX_REG_PROTECT_EN): protect = 16'h0004, write sel = 2 din = 55 -> register 2 unchanged, wr_strobe = 0, wr_err = 1 for one cycle; a write to sel = 1 then succeeds normally.
